// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus writeback: result select, register-file write port,
// forwarding bus, sticky halt flag and a saturating retired-instruction counter.
module wb_stage #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned CNT_W        = 32,
  parameter bit          BYTE_LOAD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_readData,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_nextPC,
  input  logic              in_isMemToReg,
  input  logic              in_isByteLoad,
  input  logic              in_isJAL,
  input  logic              in_writeEn,
  input  logic [REG_AW-1:0] in_writeReg,
  input  logic              in_halt,
  output logic              regWrite,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              fwdValid,
  output logic [REG_AW-1:0] fwdReg,
  output logic [DATA_W-1:0] fwdData,
  output logic              halted,
  output logic [CNT_W-1:0]  retireCount
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] read_data_q, alu_result_q, next_pc_q;
  logic              is_mem_to_reg_q, is_byte_load_q, is_jal_q;
  logic              write_en_q, halt_q;
  logic [REG_AW-1:0] write_reg_q;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;
  logic [REG_AW-1:0] wreg_hold_q, wreg_hold_d;

  logic              load_en;
  logic              retire;
  logic              reg_write;
  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] result;

  // Data fields only move on a plain advance; a flush merely kills valid.
  assign load_en = ~halted_q & ~flush & ~stall;

  always_comb begin
    valid_d = valid_q;
    if (halted_q || flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
    end
  end

  assign byte_ext = {{(DATA_W-8){read_data_q[7]}}, read_data_q[7:0]};

  always_comb begin
    result = alu_result_q;
    if (is_jal_q) begin
      result = next_pc_q;
    end else if (is_mem_to_reg_q && is_byte_load_q && BYTE_LOAD_EN) begin
      result = byte_ext;
    end else if (is_mem_to_reg_q) begin
      result = read_data_q;
    end
  end

  assign reg_write = valid_q & write_en_q & ~halted_q;

  // Anything left in the stage behind a HALT is squashed, so it is never counted.
  assign retire = valid_q & ~stall & ~halted_q;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire && (retire_cnt_q != {CNT_W{1'b1}})) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  assign halted_d     = halted_q | (valid_q & halt_q & ~stall);
  assign wdata_hold_d = reg_write ? result : wdata_hold_q;
  assign wreg_hold_d  = reg_write ? write_reg_q : wreg_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= 1'b0;
      read_data_q     <= '0;
      alu_result_q    <= '0;
      next_pc_q       <= '0;
      is_mem_to_reg_q <= 1'b0;
      is_byte_load_q  <= 1'b0;
      is_jal_q        <= 1'b0;
      write_en_q      <= 1'b0;
      write_reg_q     <= '0;
      halt_q          <= 1'b0;
      halted_q        <= 1'b0;
      retire_cnt_q    <= '0;
      wdata_hold_q    <= '0;
      wreg_hold_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      retire_cnt_q <= retire_cnt_d;
      wdata_hold_q <= wdata_hold_d;
      wreg_hold_q  <= wreg_hold_d;
      if (load_en) begin
        read_data_q     <= in_readData;
        alu_result_q    <= in_aluResult;
        next_pc_q       <= in_nextPC;
        is_mem_to_reg_q <= in_isMemToReg;
        is_byte_load_q  <= in_isByteLoad;
        is_jal_q        <= in_isJAL;
        write_en_q      <= in_writeEn;
        write_reg_q     <= in_writeReg;
        halt_q          <= in_halt;
      end
    end
  end

  assign regWrite    = reg_write;
  assign writeReg    = reg_write ? write_reg_q : wreg_hold_q;
  assign writeData   = reg_write ? result : wdata_hold_q;
  assign fwdValid    = regWrite;
  assign fwdReg      = writeReg;
  assign fwdData     = writeData;
  assign halted      = halted_q;
  assign retireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: one default instance and one with byte loads disabled
// and a 3-bit counter, both fed the same directed vectors.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [15:0] in_readData = '0, in_aluResult = '0, in_nextPC = '0;
  logic        in_isMemToReg = 1'b0, in_isByteLoad = 1'b0, in_isJAL = 1'b0;
  logic        in_writeEn = 1'b0, in_halt = 1'b0;
  logic [2:0]  in_writeReg = '0;

  logic        a_regWrite, a_fwdValid, a_halted;
  logic [2:0]  a_writeReg, a_fwdReg;
  logic [15:0] a_writeData, a_fwdData;
  logic [31:0] a_retireCount;
  logic        b_regWrite, b_fwdValid, b_halted;
  logic [2:0]  b_writeReg, b_fwdReg;
  logic [15:0] b_writeData, b_fwdData;
  logic [2:0]  b_retireCount;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  typedef struct {
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] wd;
    logic [15:0] wdb;
    logic        hlt;
    logic [31:0] ca;
    logic [2:0]  cb;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_stage dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_readData(in_readData), .in_aluResult(in_aluResult), .in_nextPC(in_nextPC),
    .in_isMemToReg(in_isMemToReg), .in_isByteLoad(in_isByteLoad), .in_isJAL(in_isJAL),
    .in_writeEn(in_writeEn), .in_writeReg(in_writeReg), .in_halt(in_halt),
    .regWrite(a_regWrite), .writeReg(a_writeReg), .writeData(a_writeData),
    .fwdValid(a_fwdValid), .fwdReg(a_fwdReg), .fwdData(a_fwdData),
    .halted(a_halted), .retireCount(a_retireCount)
  );

  wb_stage #(.CNT_W(3), .BYTE_LOAD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_readData(in_readData), .in_aluResult(in_aluResult), .in_nextPC(in_nextPC),
    .in_isMemToReg(in_isMemToReg), .in_isByteLoad(in_isByteLoad), .in_isJAL(in_isJAL),
    .in_writeEn(in_writeEn), .in_writeReg(in_writeReg), .in_halt(in_halt),
    .regWrite(b_regWrite), .writeReg(b_writeReg), .writeData(b_writeData),
    .fwdValid(b_fwdValid), .fwdReg(b_fwdReg), .fwdData(b_fwdData),
    .halted(b_halted), .retireCount(b_retireCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops one expected record per clock, just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d: rw=%0b wreg=%0d wd=%h halted=%0b cnt=%0d | b: wd=%h cnt=%0d",
               txn, a_regWrite, a_writeReg, a_writeData, a_halted, a_retireCount,
               b_writeData, b_retireCount);
      chk("a_regWrite",    32'(a_regWrite),    32'(e.rw));
      chk("a_writeReg",    32'(a_writeReg),    32'(e.wreg));
      chk("a_writeData",   32'(a_writeData),   32'(e.wd));
      chk("a_fwdValid",    32'(a_fwdValid),    32'(e.rw));
      chk("a_fwdReg",      32'(a_fwdReg),      32'(e.wreg));
      chk("a_fwdData",     32'(a_fwdData),     32'(e.wd));
      chk("a_halted",      32'(a_halted),      32'(e.hlt));
      chk("a_retireCount", a_retireCount,      e.ca);
      chk("b_regWrite",    32'(b_regWrite),    32'(e.rw));
      chk("b_writeData",   32'(b_writeData),   32'(e.wdb));
      chk("b_fwdData",     32'(b_fwdData),     32'(e.wdb));
      chk("b_retireCount", 32'(b_retireCount), 32'(e.cb));
    end
  end

  task automatic drive(input logic v, input logic we, input logic [2:0] wr,
                       input logic [15:0] alu, input logic [15:0] rd, input logic [15:0] npc,
                       input logic m2r, input logic bl, input logic jal, input logic hl,
                       input logic st, input logic fl);
    in_valid = v;  in_writeEn = we;  in_writeReg = wr;
    in_aluResult = alu;  in_readData = rd;  in_nextPC = npc;
    in_isMemToReg = m2r;  in_isByteLoad = bl;  in_isJAL = jal;
    in_halt = hl;  stall = st;  flush = fl;
  endtask

  // Push the outputs required after the coming edge, then advance to the next negedge.
  task automatic expect_out(input logic rw, input logic [2:0] wreg, input logic [15:0] wd,
                            input logic [15:0] wdb, input logic hlt, input logic [31:0] ca,
                            input logic [2:0] cb);
    exp_t e;
    e.rw = rw;  e.wreg = wreg;  e.wd = wd;  e.wdb = wdb;
    e.hlt = hlt;  e.ca = ca;  e.cb = cb;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regWrite"},    32'(a_regWrite),  0);
    chk({tag, "_writeReg"},    32'(a_writeReg),  0);
    chk({tag, "_writeData"},   32'(a_writeData), 0);
    chk({tag, "_fwdValid"},    32'(a_fwdValid),  0);
    chk({tag, "_fwdReg"},      32'(a_fwdReg),    0);
    chk({tag, "_fwdData"},     32'(a_fwdData),   0);
    chk({tag, "_halted"},      32'(a_halted),    0);
    chk({tag, "_retireCount"}, a_retireCount,    0);
    chk({tag, "_b_count"},     32'(b_retireCount), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    //    v  we wr  alu       rd        npc       m2r bl jal hl st fl
    drive(1, 1, 3, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(1, 3, 16'h1234, 16'h1234, 0, 0, 0);
    drive(1, 1, 1, 16'hFFFF, 16'h1111, 16'h0042, 1, 0, 1, 0, 0, 0);
    expect_out(1, 1, 16'h0042, 16'h0042, 0, 1, 1);
    drive(1, 1, 2, 16'h7777, 16'h00F5, 16'h0000, 1, 1, 0, 0, 0, 0);
    expect_out(1, 2, 16'hFFF5, 16'h00F5, 0, 2, 2);
    drive(1, 1, 4, 16'h0000, 16'h8081, 16'h0000, 1, 0, 0, 0, 0, 0);
    expect_out(1, 4, 16'h8081, 16'h8081, 0, 3, 3);
    drive(1, 1, 5, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(1, 5, 16'hBEEF, 16'hBEEF, 0, 4, 4);
    drive(1, 0, 6, 16'h0006, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(0, 5, 16'hBEEF, 16'hBEEF, 0, 5, 5);
    drive(1, 1, 7, 16'h0000, 16'hAB80, 16'h0000, 1, 1, 0, 0, 0, 0);
    expect_out(1, 7, 16'hFF80, 16'hAB80, 0, 6, 6);
    drive(1, 1, 1, 16'h0101, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(1, 1, 16'h0101, 16'h0101, 0, 7, 7);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 16'h2222, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0);
      expect_out(1, 1, 16'h0101, 16'h0101, 0, 7, 7);
    end
    drive(1, 1, 2, 16'h2222, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(1, 2, 16'h2222, 16'h2222, 0, 8, 7);
    drive(1, 1, 3, 16'h3333, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 1);
    expect_out(0, 2, 16'h2222, 16'h2222, 0, 8, 7);
    drive(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(0, 2, 16'h2222, 16'h2222, 0, 8, 7);
    drive(1, 0, 6, 16'h6666, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
    expect_out(0, 2, 16'h2222, 16'h2222, 0, 8, 7);
    drive(1, 1, 4, 16'h4444, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(0, 2, 16'h2222, 16'h2222, 1, 9, 7);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5, 16'h5555, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
      expect_out(0, 2, 16'h2222, 16'h2222, 1, 9, 7);
    end

    // Asynchronous reset while halted, sampled between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    drive(1, 1, 7, 16'h7777, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_out(1, 7, 16'h7777, 16'h7777, 0, 0, 0);
    drive(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    expect_out(0, 7, 16'h7777, 16'h7777, 0, 1, 1);

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
